// File: rtl/sdram_bist_if.sv
// User-side request/ack bus between the BIST traffic initiator (master)
// and the SDRAM controller (slave).
interface sdram_bist_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [9:0]        wr_bst_len;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [9:0]        rd_bst_len;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output wr_req, wr_addr, wr_data, wr_bst_len, rd_req, rd_addr, rd_bst_len,
        input  wr_ack, rd_ack, rd_data
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, wr_bst_len, rd_req, rd_addr, rd_bst_len,
        output wr_ack, rd_ack, rd_data
    );
endinterface

// File: rtl/sdram_bist.sv
// Built-in traffic initiator/checker: writes NUM_BURSTS bursts of an
// address^SEED pattern, reads them back, and reports pass/fail.
module sdram_bist #(
    parameter int                ADDR_W     = 24,
    parameter int                DATA_W     = 16,
    parameter int                BST_LEN    = 10,
    parameter int                NUM_BURSTS = 4,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [15:0]       SEED       = 16'hA5C3,
    parameter int                TIMEOUT    = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               init_end,
    sdram_bist_if.master       bus,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [15:0]        err_cnt,
    output logic [ADDR_W-1:0]  first_err_addr
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_INIT = 3'd1;
    localparam logic [2:0] S_WR        = 3'd2;
    localparam logic [2:0] S_WR_GAP    = 3'd3;
    localparam logic [2:0] S_RD        = 3'd4;
    localparam logic [2:0] S_RD_GAP    = 3'd5;
    localparam logic [2:0] S_FIN       = 3'd6;

    localparam int              WD_W       = $clog2(TIMEOUT + 1);
    localparam logic [9:0]      LAST_WORD  = 10'(BST_LEN - 1);
    localparam logic [15:0]     LAST_BURST = 16'(NUM_BURSTS);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] BST_STEP = ADDR_W'(BST_LEN);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [9:0]        wcnt_q, wcnt_d;
    logic [15:0]       bcnt_q, bcnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d, tmo_q, tmo_d;
    logic [15:0]       err_q, err_d;
    logic [ADDR_W-1:0] ferr_q, ferr_d;
    logic [ADDR_W-1:0] word_addr;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        logic [15:0] low;
        low = a[15:0] ^ SEED;
        return DATA_W'(low);
    endfunction

    assign word_addr = addr_q + ADDR_W'(wcnt_q);

    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d = state_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        wd_d    = '0;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        case (state_q)
            S_IDLE: if (start) begin
                err_d   = '0;
                ferr_d  = '0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
                tmo_d   = 1'b0;
                busy_d  = 1'b1;
                addr_d  = START_ADDR;
                wcnt_d  = '0;
                bcnt_d  = '0;
                state_d = S_WAIT_INIT;
            end
            S_WAIT_INIT: if (init_end) state_d = S_WR;
            S_WR: begin
                if (bus.wr_ack) begin
                    if (wcnt_q == LAST_WORD) begin
                        wcnt_d  = '0;
                        addr_d  = addr_q + BST_STEP;
                        bcnt_d  = bcnt_q + 16'd1;
                        state_d = S_WR_GAP;
                    end else begin
                        wcnt_d = wcnt_q + 10'd1;
                    end
                end else if (wd_q == WD_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_WR_GAP: begin
                if (bcnt_q == LAST_BURST) begin
                    bcnt_d  = '0;
                    addr_d  = START_ADDR;
                    state_d = S_RD;
                end else begin
                    state_d = S_WR;
                end
            end
            S_RD: begin
                if (bus.rd_ack) begin
                    if (bus.rd_data != pattern(word_addr)) begin
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                        if (err_q == 16'd0)    ferr_d = word_addr;
                    end
                    if (wcnt_q == LAST_WORD) begin
                        wcnt_d  = '0;
                        addr_d  = addr_q + BST_STEP;
                        bcnt_d  = bcnt_q + 16'd1;
                        state_d = S_RD_GAP;
                    end else begin
                        wcnt_d = wcnt_q + 10'd1;
                    end
                end else if (wd_q == WD_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RD_GAP: state_d = (bcnt_q == LAST_BURST) ? S_FIN : S_RD;
            S_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_q == 16'd0) && !tmo_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Write data is registered: it already shows the word the next ack will take.
        wdata_d = (state_d == S_WR) ? pattern(addr_d + ADDR_W'(wcnt_d)) : wdata_q;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            wd_q    <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            wd_q    <= wd_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
        end
    end

    // Requests decode straight from the async-reset state so reset drops them at once.
    assign bus.wr_req     = (state_q == S_WR);
    assign bus.rd_req     = (state_q == S_RD);
    assign bus.wr_addr    = addr_q;
    assign bus.rd_addr    = addr_q;
    assign bus.wr_data    = wdata_q;
    assign bus.wr_bst_len = 10'(BST_LEN);
    assign bus.rd_bst_len = 10'(BST_LEN);

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = tmo_q;
    assign err_cnt        = err_q;
    assign first_err_addr = ferr_q;
endmodule

// File: tb/tb_sdram_bist.sv
// Directed bench for sdram_bist against an ideal SDRAM user-side model.
module tb_sdram_bist;
    localparam int          AW    = 24;
    localparam int          DW    = 16;
    localparam int          BL    = 10;
    localparam int          NB    = 2;
    localparam int          TMO   = 64;
    localparam int          WORDS = BL * NB;
    localparam logic [15:0] SEED  = 16'hA5C3;

    typedef struct {
        bit    flip;
        bit    gap;
        bit    disturb;
        int    exp_err;
        int    exp_first;
        bit    exp_pass;
        string name;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wlog_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, init_end = 1'b0;
    logic busy, done, pass, timeout;
    logic [15:0]   err_cnt;
    logic [AW-1:0] first_err_addr;

    sdram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sdram_bist #(
        .ADDR_W(AW), .DATA_W(DW), .BST_LEN(BL), .NUM_BURSTS(NB),
        .START_ADDR('0), .SEED(SEED), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .init_end(init_end), .bus(bus),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit mdl_wr_en = 1'b1, flip_en = 1'b0, gap_mode = 1'b0, stray_en = 1'b0;
    logic [DW-1:0] mem [64] = '{default: 16'h0000};
    wlog_t         wlog[$];
    logic [AW-1:0] rlog[$];
    int            wr_acks = 0;
    int            mw = 0, mr = 0;
    bit            tick = 1'b0;

    // Ideal SDRAM user side: decides acks at negedge so they are stable at posedge.
    always @(negedge clk) begin
        logic [AW-1:0] a;
        bus.wr_ack  = 1'b0;
        bus.rd_ack  = 1'b0;
        bus.rd_data = '0;
        tick = ~tick;
        if (bus.wr_req !== 1'b1) mw = 0;
        if (bus.rd_req !== 1'b1) mr = 0;
        if (bus.wr_req === 1'b1 && mdl_wr_en && (!gap_mode || tick)) begin
            a = bus.wr_addr + AW'(mw);
            mem[a[5:0]] = bus.wr_data;
            wlog.push_back('{bus.wr_addr, bus.wr_data});
            mw++;
            wr_acks++;
            bus.wr_ack = 1'b1;
        end
        if (bus.rd_req === 1'b1 && (!gap_mode || tick)) begin
            a = bus.rd_addr + AW'(mr);
            if (mr == 0) rlog.push_back(bus.rd_addr);
            bus.rd_data = mem[a[5:0]] ^ ((flip_en && a == 24'd13) ? 16'h0001 : 16'h0000);
            mr++;
            bus.rd_ack = 1'b1;
        end
        if (stray_en && bus.rd_req === 1'b1) bus.wr_ack = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_done_in_budget"}, 32'(done === 1'b1), 32'd1);
    endtask

    task automatic run_scenario(input vec_t v);
        int wbase, rbase, n;
        wbase    = wlog.size();
        rbase    = rlog.size();
        flip_en  = v.flip;
        gap_mode = v.gap;
        pulse_start();
        if (v.disturb) begin
            n = 0;
            while (bus.rd_req !== 1'b1 && n < 1000) begin
                @(posedge clk); #1;
                n++;
            end
            repeat (3) @(posedge clk);
            #1;
            stray_en = 1'b1;
            init_end = 1'b0;
            pulse_start();
        end
        wait_done(v.name, 1000);
        stray_en = 1'b0;
        init_end = 1'b1;
        check({v.name, "_busy"},      32'(busy),            32'd0);
        check({v.name, "_pass"},      32'(pass),            32'(v.exp_pass));
        check({v.name, "_timeout"},   32'(timeout),         32'd0);
        check({v.name, "_err_cnt"},   32'(err_cnt),         32'(v.exp_err));
        check({v.name, "_first_err"}, 32'(first_err_addr),  32'(v.exp_first));
        check({v.name, "_wr_words"},  32'(wlog.size() - wbase), 32'(WORDS));
        for (int i = 0; i < WORDS && wbase + i < wlog.size(); i++) begin
            check($sformatf("%s_wr_addr%0d", v.name, i), 32'(wlog[wbase+i].addr), 32'((i / BL) * BL));
            check($sformatf("%s_wr_data%0d", v.name, i), 32'(wlog[wbase+i].data), 32'(16'(i) ^ SEED));
        end
        check({v.name, "_rd_bursts"}, 32'(rlog.size() - rbase), 32'(NB));
        for (int b = 0; b < NB && rbase + b < rlog.size(); b++)
            check($sformatf("%s_rd_addr%0d", v.name, b), 32'(rlog[rbase+b]), 32'(b * BL));
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit");
        $fatal(1, "bench did not finish");
    end

    initial begin
        vec_t vecs[5];
        vec_t clean_v;
        int   n, base_acks;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 0, 0,  1'b1, "clean"};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1, 13, 1'b0, "flip13"};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 0, 0,  1'b1, "clean_gap"};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 0, 0,  1'b1, "disturb_rd"};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1, 13, 1'b0, "flip13_gap"};
        clean_v = '{1'b0, 1'b0, 1'b0, 0, 0,  1'b1, "after_reset"};

        // Reset values
        #12;
        check("rst_wr_req",     32'(bus.wr_req),     32'd0);
        check("rst_rd_req",     32'(bus.rd_req),     32'd0);
        check("rst_wr_addr",    32'(bus.wr_addr),    32'd0);
        check("rst_rd_addr",    32'(bus.rd_addr),    32'd0);
        check("rst_wr_data",    32'(bus.wr_data),    32'd0);
        check("rst_wr_bst_len", 32'(bus.wr_bst_len), 32'(BL));
        check("rst_rd_bst_len", 32'(bus.rd_bst_len), 32'(BL));
        check("rst_flags",      32'({busy, done, pass, timeout}), 32'd0);
        check("rst_err_cnt",    32'(err_cnt),        32'd0);
        check("rst_first_err",  32'(first_err_addr), 32'd0);
        rst_n = 1'b1;

        // Start before controller init completes
        pulse_start();
        check("wait_busy", 32'(busy), 32'd1);
        n = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (bus.wr_req !== 1'b0) n++;
        end
        check("wait_no_req_cycles", 32'(n), 32'd0);
        init_end = 1'b1;
        #1;
        check("wait_req_same_cycle", 32'(bus.wr_req), 32'd0);
        @(posedge clk); #1;
        check("wait_req_next_cycle", 32'(bus.wr_req),  32'd1);
        check("wait_first_addr",     32'(bus.wr_addr), 32'd0);
        check("wait_first_data",     32'(bus.wr_data), 32'(SEED));
        wait_done("wait", 1000);
        check("wait_pass", 32'(pass), 32'd1);

        // Write watchdog: model never acks
        mdl_wr_en = 1'b0;
        pulse_start();
        n = 0;
        while (bus.wr_req !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("tmo_req_seen", 32'(bus.wr_req), 32'd1);
        n = 0;
        while (bus.wr_req === 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        check("tmo_req_cycles", 32'(n), 32'(TMO));
        wait_done("tmo", 100);
        check("tmo_timeout", 32'(timeout),     32'd1);
        check("tmo_pass",    32'(pass),        32'd0);
        check("tmo_busy",    32'(busy),        32'd0);
        check("tmo_rd_req",  32'(bus.rd_req),  32'd0);
        mdl_wr_en = 1'b1;

        for (int k = 0; k < 5; k++) run_scenario(vecs[k]);

        // Reset in the middle of a write burst
        base_acks = wr_acks;
        pulse_start();
        n = 0;
        while (wr_acks - base_acks < 5 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("midrst_acks", 32'(wr_acks - base_acks), 32'd5);
        check("midrst_req_before", 32'(bus.wr_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_wr_req",  32'(bus.wr_req),  32'd0);
        check("midrst_busy",    32'(busy),        32'd0);
        check("midrst_wr_data", 32'(bus.wr_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_scenario(clean_v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
